// File: rtl/pipelined_divider_hs.sv
// Pipelined restoring divider with valid/ready handshake, signed/unsigned mode,
// divide-by-zero and overflow flags, and a sideband tag carried with each beat.
module pipelined_divider_hs #(
    parameter int DIVIDENDLEN = 16,
    parameter int DIVISORLEN  = 8,
    parameter int TAGLEN      = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIVIDENDLEN-1:0] dividend,
    input  logic [DIVISORLEN-1:0]  divisor,
    input  logic                   signed_mode,
    input  logic [TAGLEN-1:0]      in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIVIDENDLEN-1:0] quotient,
    output logic [DIVISORLEN-1:0]  remainder,
    output logic                   div_by_zero,
    output logic                   overflow,
    output logic [TAGLEN-1:0]      out_tag
);

    localparam int N = DIVIDENDLEN;
    localparam int D = DIVISORLEN;
    localparam int F = N + 1;

    function automatic logic [N-1:0] mag_n(input logic signed [N-1:0] x, input logic sm);
        return (sm && x[N-1]) ? -x : x;
    endfunction

    function automatic logic [D-1:0] mag_d(input logic signed [D-1:0] x, input logic sm);
        return (sm && x[D-1]) ? -x : x;
    endfunction

    function automatic logic signed [N-1:0] fix_quotient(input logic [N-1:0] mag,
                                                         input logic neg, input logic dz,
                                                         input logic ov);
        if (dz) return '1;
        if (ov) return {1'b1, {(N-1){1'b0}}};
        return neg ? -mag : mag;
    endfunction

    function automatic logic signed [D-1:0] fix_remainder(input logic [D-1:0] mag,
                                                          input logic neg, input logic dz,
                                                          input logic ov);
        if (dz || ov) return '0;
        return neg ? -mag : mag;
    endfunction

    logic                     adv;
    logic                     vld_p   [0:F];
    logic [N-1:0]             dvd_p   [0:N-1];
    logic [D-1:0]             dsr_p   [0:N-1];
    logic [D-1:0]             rem_p   [0:N];
    logic [N-1:0]             quo_p   [0:N];
    logic                     qneg_p  [0:N];
    logic                     rneg_p  [0:N];
    logic                     dz_p    [0:F];
    logic                     ov_p    [0:F];
    logic [TAGLEN-1:0]        tag_p   [0:F];
    logic signed [N-1:0]      quo_out_p;
    logic signed [D-1:0]      rem_out_p;

    logic [D-1:0]             rem_nxt [1:N];
    logic [N-1:0]             quo_nxt [1:N];

    assign adv       = out_ready | ~vld_p[F];
    assign in_ready  = adv & ~reset;
    assign out_valid = vld_p[F];

    // Restoring step: shift in the next dividend bit, keep the difference if it fits.
    always_comb begin
        for (int i = 1; i <= N; i++) begin
            logic [D:0] trial;
            logic       fits;
            trial      = {rem_p[i-1], dvd_p[i-1][N-i]};
            fits       = trial >= {1'b0, dsr_p[i-1]};
            rem_nxt[i] = fits ? D'(trial - {1'b0, dsr_p[i-1]}) : trial[D-1:0];
            quo_nxt[i] = quo_p[i-1] | (fits ? (N'(1) << (N - i)) : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= F; i++) vld_p[i] <= 1'b0;
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int i = 1; i <= F; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (adv) begin
            // Stage 0: operand register, magnitudes and sign/flag capture
            dvd_p[0]  <= mag_n(dividend, signed_mode);
            dsr_p[0]  <= mag_d(divisor, signed_mode);
            rem_p[0]  <= '0;
            quo_p[0]  <= '0;
            qneg_p[0] <= signed_mode & (dividend[N-1] ^ divisor[D-1]);
            rneg_p[0] <= signed_mode & dividend[N-1];
            dz_p[0]   <= (divisor == '0);
            ov_p[0]   <= signed_mode && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
            tag_p[0]  <= in_tag;

            // Stages 1..N: one quotient bit each, MSB first
            for (int i = 1; i < N; i++) begin
                dvd_p[i] <= dvd_p[i-1];
                dsr_p[i] <= dsr_p[i-1];
            end
            for (int i = 1; i <= N; i++) begin
                rem_p[i]  <= rem_nxt[i];
                quo_p[i]  <= quo_nxt[i];
                qneg_p[i] <= qneg_p[i-1];
                rneg_p[i] <= rneg_p[i-1];
                dz_p[i]   <= dz_p[i-1];
                ov_p[i]   <= ov_p[i-1];
                tag_p[i]  <= tag_p[i-1];
            end

            // Output stage: sign fix-up and flag overrides
            quo_out_p <= fix_quotient(quo_p[N], qneg_p[N], dz_p[N], ov_p[N]);
            rem_out_p <= fix_remainder(rem_p[N], rneg_p[N], dz_p[N], ov_p[N]);
            dz_p[F]   <= dz_p[N];
            ov_p[F]   <= ov_p[N];
            tag_p[F]  <= tag_p[N];
        end
    end

    // Result fields read as zero whenever no beat is presented.
    assign quotient    = vld_p[F] ? quo_out_p : '0;
    assign remainder   = vld_p[F] ? rem_out_p : '0;
    assign div_by_zero = vld_p[F] & dz_p[F];
    assign overflow    = vld_p[F] & ov_p[F];
    assign out_tag     = vld_p[F] ? tag_p[F] : '0;

endmodule

// File: tb/tb_pipelined_divider_hs.sv
// Self-checking bench for pipelined_divider_hs: directed vectors, random
// streaming with backpressure, bubbles and reset cases against a reference model.
module tb_pipelined_divider_hs;

    localparam int LAT = 17;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic        sm;
        logic [3:0]  tag;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        logic [3:0]  tag;
        int          edge_n;
        bit          chk_lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        signed_mode = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;
    logic [3:0]  out_tag;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t expq[$];

    logic [15:0] pq;
    logic [7:0]  pr;
    logic        pdz, pov;
    logic [3:0]  ptag;
    bit          pstall = 1'b0;

    pipelined_divider_hs #(.DIVIDENDLEN(16), .DIVISORLEN(8), .TAGLEN(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .signed_mode(signed_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow),
        .out_tag(out_tag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic void ref_div(input logic [15:0] a, input logic [7:0] b, input logic sm,
                                    output logic [15:0] q, output logic [7:0] r,
                                    output logic dz, output logic ov);
        int sa, sd, qi, ri;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 8'h00) begin
            q = 16'hFFFF; r = 8'h00; dz = 1'b1;
        end else if (sm && a == 16'h8000 && b == 8'hFF) begin
            q = 16'h8000; r = 8'h00; ov = 1'b1;
        end else begin
            if (sm) begin
                sa = int'($signed(a));
                sd = int'($signed(b));
            end else begin
                sa = int'(a);
                sd = int'(b);
            end
            qi = sa / sd;
            ri = sa % sd;
            q = qi[15:0];
            r = ri[7:0];
        end
    endfunction

    task automatic monitor_step();
        exp_t e;
        check("in_ready", 32'(in_ready), 32'(!reset && (out_ready || !out_valid)));
        if (!out_valid) check("idle_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        if (pstall)
            check("stall_hold", {1'b0, quotient, remainder, div_by_zero, overflow, out_tag, out_valid},
                  {1'b0, pq, pr, pdz, pov, ptag, 1'b1});
        pstall = out_valid && !out_ready && !reset;
        pq = quotient; pr = remainder; pdz = div_by_zero; pov = overflow; ptag = out_tag;
        if (out_valid && out_ready && !reset) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: actual q=%0h tag=%0h required no beat (cycle %0d)",
                         quotient, out_tag, cyc);
            end else begin
                e = expq.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("flags", {30'd0, div_by_zero, overflow}, {30'd0, e.dz, e.ov});
                check("out_tag", 32'(out_tag), 32'(e.tag));
                if (e.chk_lat) check("latency", cyc - e.edge_n, LAT);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (mon_en) monitor_step();
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] b, input logic sm,
                        input logic [3:0] tg, input logic [15:0] eq, input logic [7:0] er,
                        input logic edz, input logic eov, input bit lat);
        bit acc = 1'b0;
        int n = 0;
        dividend = a; divisor = b; signed_mode = sm; in_tag = tg; in_valid = 1'b1;
        while (!acc && n < 1000) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) expq.push_back('{q: eq, r: er, dz: edz, ov: eov, tag: tg, edge_n: cyc, chk_lat: lat});
        else begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: actual in_ready=0 for %0d cycles required acceptance", n);
        end
    endtask

    task automatic send_model(input logic [15:0] a, input logic [7:0] b, input logic sm,
                              input logic [3:0] tg, input bit lat);
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz, ov;
        ref_div(a, b, sm, q, r, dz, ov);
        send(a, b, sm, tg, q, r, dz, ov, lat);
    endtask

    task automatic send_random(input logic [3:0] tg, input bit lat);
        logic [15:0] a;
        logic [7:0]  b;
        logic        sm;
        a  = 16'($urandom);
        b  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
        sm = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 11) == 0) begin
            a = 16'h8000;
            b = 8'hFF;
        end
        send_model(a, b, sm, tg, lat);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 300) begin
            idle(1);
            n++;
        end
        check("drain_empty", expq.size(), 0);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        expq.delete();
        check("reset_out_valid", 32'(out_valid), 32'd0);
    endtask

    vec_t tbl [12];

    initial begin
        tbl = '{
            '{16'h03E8, 8'h07, 1'b0, 4'h3, 16'h008E, 8'h06, 1'b0, 1'b0},
            '{16'hFC18, 8'h07, 1'b1, 4'h4, 16'hFF72, 8'hFA, 1'b0, 1'b0},
            '{16'h03E8, 8'hF9, 1'b1, 4'h5, 16'hFF72, 8'h06, 1'b0, 1'b0},
            '{16'hFC18, 8'hF9, 1'b1, 4'h6, 16'h008E, 8'hFA, 1'b0, 1'b0},
            '{16'h1234, 8'h00, 1'b0, 4'h7, 16'hFFFF, 8'h00, 1'b1, 1'b0},
            '{16'h1234, 8'h00, 1'b1, 4'h8, 16'hFFFF, 8'h00, 1'b1, 1'b0},
            '{16'h8000, 8'hFF, 1'b1, 4'h9, 16'h8000, 8'h00, 1'b0, 1'b1},
            '{16'h8000, 8'hFF, 1'b0, 4'hA, 16'h0080, 8'h80, 1'b0, 1'b0},
            '{16'hFFFF, 8'hFF, 1'b0, 4'hB, 16'h0101, 8'h00, 1'b0, 1'b0},
            '{16'hFFFF, 8'hFF, 1'b1, 4'hC, 16'h0001, 8'h00, 1'b0, 1'b0},
            '{16'h7FFF, 8'h80, 1'b1, 4'hD, 16'hFF01, 8'h7F, 1'b0, 1'b0},
            '{16'h0005, 8'h07, 1'b0, 4'hE, 16'h0000, 8'h05, 1'b0, 1'b0}
        };

        // Reset state
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        @(negedge clock);
        check("reset_state", {1'b0, out_valid, quotient, remainder, div_by_zero, overflow, out_tag},
              32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed vectors, back to back, latency checked
        for (int i = 0; i < 12; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].tag, tbl[i].q, tbl[i].r,
                 tbl[i].dz, tbl[i].ov, 1'b1);
        drain();

        // Bubbles: 1,0,0,1
        send_random(4'h1, 1'b1);
        idle(2);
        send_random(4'h2, 1'b1);
        drain();

        // Streaming with backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) send_random(4'(i % 16), 1'b0);
            end
            begin
                idle(25);
                out_ready = 1'b0;
                idle(5);
                out_ready = 1'b1;
                idle(6);
                out_ready = 1'b0;
                idle(1);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while stalled with a full output
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_random(4'(i), 1'b0);
        idle(25);
        check("stalled_out_valid", 32'(out_valid), 32'd1);
        reset_pulse();
        out_ready = 1'b1;
        idle(30);

        // Reset with beats in flight, then a fresh beat
        for (int i = 0; i < 10; i++) send_random(4'(i), 1'b0);
        reset_pulse();
        idle(40);
        send(16'd50, 8'd5, 1'b0, 4'hF, 16'd10, 8'd0, 1'b0, 1'b0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
